// File: rtl/rx_copy_sched.sv
// Receive copy scheduler: groups redundant copies by id, forwards the first valid copy
// through an L-cycle delay line and closes each group with a mask/lost report.
// Optional statistics counters are enabled by defining RX_COPY_SCHED_STATS_EN.
module rx_copy_sched #(
    parameter int WHEREISID   = 0,
    parameter int NCOPY       = 5,
    parameter int GAP_TIMEOUT = 320,
    parameter int TW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic [7:0]       rxdata,
    output logic             fwd_en,
    output logic [7:0]       fwd_data,
    output logic             group_done,
    output logic [NCOPY-1:0] copy_mask,
    output logic             group_lost,
    output logic             bad_pkt
`ifdef RX_COPY_SCHED_STATS_EN
    ,
    output logic [15:0]      grp_total,
    output logic [15:0]      grp_lost_cnt
`endif
);

    localparam int L = WHEREISID + 1;
    localparam logic [NCOPY-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, HDR, BODY, GAP} state_t;

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NCOPY-1:0]  mask_q, mask_d;
    logic              pkt_bad_q, pkt_bad_d;
    logic              fwd_flag_q, fwd_flag_d;
    logic [L-1:0]      dl_en_q, dl_en_d;
    logic [7:0]        dl_data_q [L];
    logic [7:0]        dl_data_d [L];
    logic              done_q, done_d;
    logic [NCOPY-1:0]  cmask_q, cmask_d;
    logic              lost_q, lost_d;
    logic              bad_q, bad_d;

    logic              start, pkt_end, id_hit, id_valid, timeout;
    logic              close, bad_set, fwd_decide, delayed_start;
    logic [7:0]        idx;
    logic [NCOPY-1:0]  id_bit, base_mask, close_mask;
    logic [L:0]        en_chain;

    // prev_q resets high so a packet already in flight when rst drops is not seen as a start
    assign start    = rx_en & ~prev_q;
    assign pkt_end  = ~rx_en & prev_q;
    assign idx      = start ? 8'd0 : cnt_q;
    assign id_hit   = rx_en && (start || state_q == HDR) && (idx == 8'(WHEREISID));
    assign id_valid = (rxdata != 8'd0) && (rxdata <= 8'(NCOPY));
    assign timeout  = (state_q == GAP) && (timer_q == TW'(GAP_TIMEOUT));
    assign en_chain = {dl_en_q, rx_en};
    // The first byte of a packet enters the last delay stage exactly at its id byte
    assign delayed_start = en_chain[L-1] & ~en_chain[L];

    always_comb begin
        id_bit = '0;
        for (int i = 0; i < NCOPY; i++) id_bit[i] = (rxdata == 8'(i + 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            timer_q    <= '0;
            mask_q     <= '0;
            pkt_bad_q  <= 1'b0;
            fwd_flag_q <= 1'b0;
            dl_en_q    <= '0;
            dl_data_q  <= '{default: '0};
            done_q     <= 1'b0;
            cmask_q    <= '0;
            lost_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            mask_q     <= mask_d;
            pkt_bad_q  <= pkt_bad_d;
            fwd_flag_q <= fwd_flag_d;
            dl_en_q    <= dl_en_d;
            dl_data_q  <= dl_data_d;
            done_q     <= done_d;
            cmask_q    <= cmask_d;
            lost_q     <= lost_d;
            bad_q      <= bad_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        mask_d     = mask_q;
        pkt_bad_d  = pkt_bad_q;
        close      = 1'b0;
        close_mask = mask_q;
        bad_set    = 1'b0;
        fwd_decide = 1'b0;
        base_mask  = timeout ? '0 : mask_q;

        // Timeout wins over a coinciding start; the new packet sees an empty group
        if (timeout) begin
            close  = 1'b1;
            mask_d = '0;
        end
        if (start) pkt_bad_d = 1'b0;
        if (id_hit) begin
            pkt_bad_d = ~id_valid;
            if (id_valid) begin
                if (base_mask == '0) begin
                    mask_d     = id_bit;
                    fwd_decide = 1'b1;
                end else if ((base_mask & id_bit) != '0) begin
                    close      = 1'b1;
                    mask_d     = id_bit;
                    fwd_decide = 1'b1;
                end else begin
                    mask_d = base_mask | id_bit;
                end
            end
        end

        case (state_q)
            IDLE, GAP: begin
                if (start)
                    state_d = id_hit ? BODY : HDR;
                else if (state_q == GAP) begin
                    if (timeout) state_d = IDLE;
                    else         timer_d = timer_q + TW'(1);
                end
            end
            HDR: begin
                if (pkt_end) begin
                    bad_set = 1'b1;
                    state_d = (mask_q != '0) ? GAP : IDLE;
                    timer_d = TW'(1);
                end else if (id_hit) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                if (pkt_end) begin
                    bad_set = pkt_bad_q;
                    timer_d = TW'(1);
                    if (mask_q == ALL_ONES) begin
                        close   = 1'b1;
                        mask_d  = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = (mask_q != '0) ? GAP : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prev_d       = rx_en;
        cnt_d        = start ? 8'd1 : ((rx_en && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q);
        dl_en_d      = en_chain[L-1:0];
        dl_data_d[0] = rxdata;
        for (int k = 1; k < L; k++) dl_data_d[k] = dl_data_q[k-1];
        fwd_flag_d   = delayed_start ? fwd_decide : fwd_flag_q;
        done_d       = close;
        cmask_d      = close ? close_mask : cmask_q;
        lost_d       = close ? (close_mask != ALL_ONES) : lost_q;
        bad_d        = bad_set;
    end

    assign fwd_en     = dl_en_q[L-1] & fwd_flag_q;
    assign fwd_data   = dl_data_q[L-1];
    assign group_done = done_q;
    assign copy_mask  = cmask_q;
    assign group_lost = lost_q;
    assign bad_pkt    = bad_q;

`ifdef RX_COPY_SCHED_STATS_EN
    logic [15:0] tot_q, tot_d, lcnt_q, lcnt_d;

    always_comb begin
        tot_d  = (done_q && tot_q != 16'hFFFF) ? tot_q + 16'd1 : tot_q;
        lcnt_d = (done_q && lost_q && lcnt_q != 16'hFFFF) ? lcnt_q + 16'd1 : lcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q  <= '0;
            lcnt_q <= '0;
        end else begin
            tot_q  <= tot_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign grp_total    = tot_q;
    assign grp_lost_cnt = lcnt_q;
`endif

endmodule
